// File: rtl/exec_scheduler.sv
// exec_scheduler: round-robin issue selection for the add/sub and mul/div
// reservation-station classes, plus sequencing of the single-cycle add unit
// and the non-pipelined mul/div unit. Adds are held off so they never share
// the result bus (CDB) cycle with a mul/div completion.
//
// Ports:
//   clk1, rst_n          clock (rising edge), async active-low reset
//   flush                synchronous squash of all in-flight work
//   add_rdy, mul_rdy     per-entry ready (busy, operands valid, not issued)
//   mul_is_div           per-entry divide flag (selects DIV_LAT)
//   add_issue, add_idx   combinational add grant (idx 0 when no grant)
//   mul_issue, mul_idx   combinational mul grant (idx 0 when no grant)
//   mul_busy             mul/div unit occupied
//   cdb_valid/src/idx    registered result-bus broadcast (src 1 = mul unit)
module exec_scheduler #(
  parameter int unsigned NRS     = 8,
  parameter int unsigned IDXW    = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 6
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [NRS-1:0]  add_rdy,
  input  logic [NRS-1:0]  mul_rdy,
  input  logic [NRS-1:0]  mul_is_div,
  output logic            add_issue,
  output logic [IDXW-1:0] add_idx,
  output logic            mul_issue,
  output logic [IDXW-1:0] mul_idx,
  output logic            mul_busy,
  output logic            cdb_valid,
  output logic            cdb_src,
  output logic [IDXW-1:0] cdb_idx
);

  localparam int unsigned MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  // Counter only ever holds latency-1.
  localparam int unsigned CNTW   = $clog2(MAXLAT);

  logic [IDXW-1:0] add_ptr, mul_ptr, mul_tag;
  logic [CNTW-1:0] mul_cnt;

  logic            add_found, mul_found;
  logic [IDXW-1:0] add_sel, mul_sel;
  logic            mul_last;

  // First set bit at or after ptr, wrapping modulo NRS; MSB of result = found.
  function automatic logic [IDXW:0] rr_pick(input logic [NRS-1:0]  rdy,
                                            input logic [IDXW-1:0] ptr);
    logic [IDXW:0] res;
    int unsigned   j;
    res = '0;
    for (int unsigned k = 0; k < NRS; k++) begin
      j = (32'(ptr) + k) % NRS;
      if (!res[IDXW] && rdy[IDXW'(j)]) begin
        res = {1'b1, IDXW'(j)};
      end
    end
    return res;
  endfunction

  function automatic logic [IDXW-1:0] ptr_after(input logic [IDXW-1:0] idx);
    return IDXW'((32'(idx) + 32'd1) % NRS);
  endfunction

  // Grant selection and issue gating.
  always_comb begin
    {add_found, add_sel} = rr_pick(add_rdy, add_ptr);
    {mul_found, mul_sel} = rr_pick(mul_rdy, mul_ptr);
    mul_last  = (mul_cnt == CNTW'(1));
    // An add issued now would hit the CDB together with the finishing mul.
    add_issue = add_found && !flush && !mul_last;
    mul_issue = mul_found && !flush && (mul_cnt == '0);
    add_idx   = add_issue ? add_sel : '0;
    mul_idx   = mul_issue ? mul_sel : '0;
    mul_busy  = (mul_cnt != '0);
  end

  // Pointers, mul/div sequencing and the CDB register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      add_ptr   <= '0;
      mul_ptr   <= '0;
      mul_cnt   <= '0;
      mul_tag   <= '0;
      cdb_valid <= 1'b0;
      cdb_src   <= 1'b0;
      cdb_idx   <= '0;
    end else if (flush) begin
      add_ptr   <= '0;
      mul_ptr   <= '0;
      mul_cnt   <= '0;
      cdb_valid <= 1'b0;
    end else begin
      if (add_issue) begin
        add_ptr <= ptr_after(add_sel);
      end
      if (mul_issue) begin
        mul_ptr <= ptr_after(mul_sel);
        mul_tag <= mul_sel;
        mul_cnt <= mul_is_div[mul_sel] ? CNTW'(DIV_LAT - 1) : CNTW'(MUL_LAT - 1);
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNTW'(1);
      end
      // Mul completion wins the bus if both sources ever coincide.
      if (mul_last) begin
        cdb_valid <= 1'b1;
        cdb_src   <= 1'b1;
        cdb_idx   <= mul_tag;
      end else if (add_issue) begin
        cdb_valid <= 1'b1;
        cdb_src   <= 1'b0;
        cdb_idx   <= add_sel;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Testbench for exec_scheduler: directed scenarios plus randomized ready
// traffic, all compared each cycle against a cycle-count based reference model.
module tb_exec_scheduler;

  logic       clk1 = 1'b0;
  logic       rst_n, flush;
  logic [7:0] add_rdy, mul_rdy, mul_is_div;
  logic       add_issue, mul_issue, mul_busy, cdb_valid, cdb_src;
  logic [2:0] add_idx, mul_idx, cdb_idx;

  exec_scheduler #(.NRS(8), .IDXW(3), .MUL_LAT(3), .DIV_LAT(6)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .add_rdy(add_rdy), .mul_rdy(mul_rdy), .mul_is_div(mul_is_div),
    .add_issue(add_issue), .add_idx(add_idx),
    .mul_issue(mul_issue), .mul_idx(mul_idx), .mul_busy(mul_busy),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_idx(cdb_idx)
  );

  always #5 clk1 = ~clk1;

  int vecs = 0;
  int miscompares = 0;

  // Reference model: the mul unit is described by the absolute cycle its
  // result is due on the bus, not by a counter.
  int cyc = 0;
  int m_aptr, m_mptr, m_done, m_tag;
  bit m_pend;
  bit e_cv, e_cs;
  int e_ci;
  bit x_ai, x_mi, x_busy;
  int x_aidx, x_midx;

  logic [13:0] obs;
  assign obs = {add_issue, add_idx, mul_issue, mul_idx, mul_busy, cdb_valid, cdb_src, cdb_idx};

  function automatic logic [13:0] expv();
    return {x_ai, 3'(x_aidx), x_mi, 3'(x_midx), x_busy, e_cv, e_cs, 3'(e_ci)};
  endfunction

  function automatic int rr(input logic [7:0] r, input int p);
    logic [2:0] j;
    for (int k = 0; k < 8; k++) begin
      j = 3'((p + k) % 8);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_aptr = 0; m_mptr = 0; m_pend = 0; m_done = 0; m_tag = 0;
    e_cv = 0; e_cs = 0; e_ci = 0;
  endtask

  task automatic model_eval();
    int  ag, mg;
    bit  active;
    ag     = rr(add_rdy, m_aptr);
    mg     = rr(mul_rdy, m_mptr);
    active = m_pend && (cyc < m_done);
    x_ai   = (ag >= 0) && !flush && !(m_pend && cyc == m_done - 1);
    x_mi   = (mg >= 0) && !flush && !active;
    x_aidx = x_ai ? ag : 0;
    x_midx = x_mi ? mg : 0;
    x_busy = active;
  endtask

  task automatic model_advance();
    if (flush) begin
      m_pend = 0; e_cv = 0; m_aptr = 0; m_mptr = 0;
    end else begin
      if (m_pend && cyc + 1 == m_done) begin
        e_cv = 1; e_cs = 1; e_ci = m_tag;
      end else if (x_ai) begin
        e_cv = 1; e_cs = 0; e_ci = x_aidx;
      end else begin
        e_cv = 0;
      end
      if (x_ai) m_aptr = (x_aidx + 1) % 8;
      if (x_mi) begin
        m_pend = 1;
        m_tag  = x_midx;
        m_done = cyc + (mul_is_div[3'(x_midx)] ? 6 : 3);
        m_mptr = (x_midx + 1) % 8;
      end
    end
    cyc++;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advance one clock; the RS side drops the ready bit of every granted entry.
  task automatic tick();
    model_advance();
    @(posedge clk1);
    #1;
    if (x_ai) add_rdy[3'(x_aidx)] = 1'b0;
    if (x_mi) mul_rdy[3'(x_midx)] = 1'b0;
  endtask

  task automatic quiesce();
    add_rdy = '0; mul_rdy = '0; flush = 1'b1;
    settle();
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; add_rdy = '0; mul_rdy = '0; mul_is_div = '0;
    #12;
    model_reset();
    model_eval();
    vecs++;
    if (obs !== 14'h0) begin
      $display("FAIL reset got=%h exp=%h", obs, 14'h0); miscompares++;
    end
    @(posedge clk1); #2 rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic test_two_bits();
    quiesce();
    add_rdy = 8'h81;
    for (int t = 0; t < 3; t++) begin
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL two_bits t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      vecs++;
      if (t == 0 && {add_issue, add_idx} !== 4'b1_000) begin
        $display("FAIL two_bits_grant0 got=%b exp=1000", {add_issue, add_idx}); miscompares++;
      end else if (t == 1 && {add_issue, add_idx, cdb_valid, cdb_src, cdb_idx} !== 9'b1_111_1_0_000) begin
        $display("FAIL two_bits_grant7 got=%b exp=111110000", {add_issue, add_idx, cdb_valid, cdb_src, cdb_idx}); miscompares++;
      end else if (t == 2 && {add_issue, cdb_valid, cdb_src, cdb_idx} !== 6'b0_1_0_111) begin
        $display("FAIL two_bits_cdb7 got=%b exp=010111", {add_issue, cdb_valid, cdb_src, cdb_idx}); miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_rotate();
    quiesce();
    add_rdy = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL rotate k=%0d got=%h exp=%h", k, obs, expv()); miscompares++;
      end
      vecs++;
      if ({add_issue, add_idx} !== {1'b1, 3'(k % 8)}) begin
        $display("FAIL rotate_order k=%0d got=%b exp=%b", k, {add_issue, add_idx}, {1'b1, 3'(k % 8)}); miscompares++;
      end
      tick();
      add_rdy = 8'hFF & ~(8'h01 << x_aidx);
    end
  endtask

  task automatic test_mul_add();
    quiesce();
    mul_is_div = '0; mul_rdy = 8'h04; add_rdy = 8'h10;
    for (int t = 0; t < 6; t++) begin
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL mul_add t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      if (t < 4) begin
        vecs++;
        if (add_issue !== (t != 2)) begin
          $display("FAIL mul_add_gate t=%0d got=%b exp=%b", t, add_issue, (t != 2)); miscompares++;
        end
      end
      if (t == 3) begin
        vecs++;
        if ({cdb_valid, cdb_src, cdb_idx} !== 5'b1_1_010) begin
          $display("FAIL mul_add_cdb got=%b exp=11010", {cdb_valid, cdb_src, cdb_idx}); miscompares++;
        end
      end
      tick();
      add_rdy[4] = 1'b1;
    end
    add_rdy = '0;
  endtask

  task automatic test_div_mul();
    quiesce();
    mul_is_div = 8'h20; mul_rdy = 8'h20; add_rdy = '0;
    for (int t = 0; t < 11; t++) begin
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL div_mul t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      if (t <= 6) begin
        vecs++;
        if (mul_busy !== (t >= 1 && t <= 5)) begin
          $display("FAIL div_busy t=%0d got=%b exp=%b", t, mul_busy, (t >= 1 && t <= 5)); miscompares++;
        end
      end
      if (t == 6) begin
        vecs++;
        if ({mul_issue, mul_idx, cdb_valid, cdb_src, cdb_idx} !== 9'b1_001_1_1_101) begin
          $display("FAIL div_done got=%b exp=100111101", {mul_issue, mul_idx, cdb_valid, cdb_src, cdb_idx}); miscompares++;
        end
      end
      if (t == 9) begin
        vecs++;
        if ({cdb_valid, cdb_src, cdb_idx} !== 5'b1_1_001) begin
          $display("FAIL mul_after_div got=%b exp=11001", {cdb_valid, cdb_src, cdb_idx}); miscompares++;
        end
      end
      tick();
      if (t == 0) mul_rdy[1] = 1'b1;
    end
  endtask

  task automatic test_flush();
    quiesce();
    mul_is_div = 8'h20; mul_rdy = 8'h20; add_rdy = '0;
    for (int t = 0; t < 10; t++) begin
      flush = (t == 2);
      if (t == 2) add_rdy = 8'h88;
      if (t == 3) mul_rdy = 8'h42;
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL flush t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      if (t == 2) begin
        vecs++;
        if ({add_issue, mul_issue} !== 2'b00) begin
          $display("FAIL flush_noissue got=%b exp=00", {add_issue, mul_issue}); miscompares++;
        end
      end
      if (t == 3) begin
        vecs++;
        if ({mul_busy, cdb_valid, add_idx, mul_idx} !== 8'b0_0_011_001) begin
          $display("FAIL flush_after got=%b exp=00011001", {mul_busy, cdb_valid, add_idx, mul_idx}); miscompares++;
        end
      end
      vecs++;
      if (cdb_valid && cdb_src && cdb_idx == 3'd5) begin
        $display("FAIL flush_stale t=%0d got=src1_idx5 exp=none", t); miscompares++;
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    quiesce();
    mul_is_div = '0; mul_rdy = 8'h04; add_rdy = 8'h01;
    for (int t = 0; t < 2; t++) begin
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL areset_pre t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      tick();
    end
    add_rdy = '0; mul_rdy = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    model_eval();
    vecs++;
    if (obs !== 14'h0) begin
      $display("FAIL areset_async got=%h exp=%h", obs, 14'h0); miscompares++;
    end
    @(posedge clk1); #3 rst_n = 1'b1;
    @(posedge clk1); #1;
    for (int t = 0; t < 5; t++) begin
      settle();
      vecs++;
      if (obs !== expv() || cdb_valid !== 1'b0) begin
        $display("FAIL areset_post t=%0d got=%h exp=%h", t, obs, expv()); miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    quiesce();
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 8; i++) begin
        if (!add_rdy[i] && $urandom_range(0, 2) == 0) add_rdy[i] = 1'b1;
        if (!mul_rdy[i] && $urandom_range(0, 3) == 0) begin
          mul_rdy[i]    = 1'b1;
          mul_is_div[i] = 1'($urandom_range(0, 1));
        end
      end
      settle();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL random n=%0d got=%h exp=%h", n, obs, expv()); miscompares++;
      end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_bits();
    test_rotate();
    test_mul_add();
    test_div_mul();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_scheduler.md
# exec_scheduler

Issue scheduler and result-bus arbiter for the Tomasulo execution stage. Each cycle it selects at most one ready add/sub reservation-station entry and at most one ready mul/div entry, fairly, using round-robin. It sequences the single-cycle add/sub unit and the non-pipelined multi-cycle mul/div unit. Issue is timed so that the two units never complete in the same cycle on the shared result bus (CDB) that writes ROB and regbank.

## Interface
- NRS, 8, reservation-station entries per class (add_array, mul_array)
- IDXW, 3, entry index width; log2(NRS)
- MUL_LAT, 3, mul latency in cycles from issue to CDB; must be ≥2
- DIV_LAT, 6, div latency in cycles from issue to CDB; must be ≥2

Ports:
- clk1  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all in-flight work
- add_rdy  in  NRS  add-class entry i is busy with both operands valid and not yet issued
- mul_rdy  in  NRS  mul-class entry i is busy with both operands valid and not yet issued
- mul_is_div  in  NRS  mul-class entry i holds a divide; selects DIV_LAT
- add_issue  out  1  combinational; add entry add_idx issues this cycle
- add_idx  out  IDXW  granted add entry; 0 when add_issue=0
- mul_issue  out  1  combinational; mul entry mul_idx issues this cycle
- mul_idx  out  IDXW  granted mul entry; 0 when mul_issue=0
- mul_busy  out  1  mul/div unit occupied
- cdb_valid  out  1  registered; a result broadcasts this cycle
- cdb_src  out  1  0 = add unit, 1 = mul unit
- cdb_idx  out  IDXW  reservation-station index of the broadcasting entry

## Operation
- State: add_ptr and mul_ptr (round-robin pointers), mul_cnt (down-counter), mul_tag (index of the in-flight mul entry), and the registered CDB outputs.
- Round-robin grant:
  - The scan starts at the class pointer and wraps modulo NRS.
  - The first set bit wins.
  - On a grant, ptr ← idx+1, wrapping NRS-1 → 0. The pointer is unchanged when there is no grant.
- Add issue condition: add_rdy≠0, flush=0, and mul_cnt≠1. The mul_cnt≠1 term blocks an add whose result would land on the CDB in the same cycle as a mul completion.
- Mul issue condition: mul_rdy≠0, flush=0, and mul_cnt=0 (unit idle).
- Both classes may issue in the same cycle.
- On mul issue: mul_cnt ← (mul_is_div[idx] ? DIV_LAT : MUL_LAT) − 1, and mul_tag ← idx.
- While mul_cnt>0, mul_cnt decrements by 1 each cycle.
- mul_busy = (mul_cnt≠0).
- CDB register update at each edge:
  - If mul_cnt=1: cdb_valid←1, cdb_src←1, cdb_idx←mul_tag.
  - Else if an add issued: cdb_valid←1, cdb_src←0, cdb_idx←add_idx.
  - Else cdb_valid←0, and cdb_src and cdb_idx hold their values.
- The issue rules make the two CDB sources mutually exclusive. If both are ever asserted, mul takes priority.
- The RS clears its ready bit on the edge where issue=1. The scheduler never grants an index whose ready bit is 0.
- flush: at the edge, mul_cnt←0, cdb_valid←0, add_ptr←0, mul_ptr←0. No issue occurs in the flush cycle.

## Timing
- Reset (async, rst_n=0): mul_cnt=0, mul_tag=0, add_ptr=0, mul_ptr=0, cdb_valid=0, cdb_src=0, cdb_idx=0. Consequently add_issue, mul_issue and mul_busy read 0 until ready bits arrive.
- Add unit: issue in cycle t → cdb_valid, src 0, in cycle t+1. Back-to-back add issue is allowed every cycle.
- Mul unit: issue in cycle t with latency L → mul_busy high for cycles t+1 … t+L−1; CDB src 1 in cycle t+L.
  - A new mul may issue in cycle t+L, the same cycle as the broadcast.
  - Add issue is suppressed in cycle t+L−1 only.
- Reset asserted mid-operation drops all in-flight work immediately. No CDB pulse is produced for it.
- Issue outputs are combinational from the inputs and registered state. There is no input-to-output flop on the grant path.

## Test plan
- Reset, then add_rdy=8'b1000_0001 held, clearing each granted bit → add_issue with add_idx 0 then 7; cdb_valid with src 0 and idx 0 then 7 one cycle later each.
- add_rdy=8'hFF kept asserted, with granted bits cleared and re-set one cycle later → grants rotate 0,1,…,7,0; each index is granted once per 8 consecutive grants.
- Mul issue of entry 2 (MUL_LAT=3) at t=0 with add_rdy bit 4 set continuously →
  - add issues at t=0 and t=1, none at t=2, and again at t=3;
  - CDB shows add@1, add@2, mul idx 2@3, add@4;
  - cdb_valid is never double-driven.
- Div of entry 5 (DIV_LAT=6) issued at t=0, mul_rdy bit 1 set at t=1 → mul_busy high t=1..5; entry 1 issues at t=6; CDB src 1 idx 5 at t=6; entry 1 (MUL_LAT=3) broadcasts at t=9.
- flush at t=2 during a div issued at t=0 → no issue at t=2; mul_busy=0 and cdb_valid=0 at t=3; no src-1 broadcast ever; the pointers restart at 0.
- rst_n pulsed low asynchronously mid-mul → outputs go to reset values before the next clk1 edge; no stale CDB pulse after release.
